lsu_data_mem: RTL
=================

Name: lsu_data_mem

Overview:
- Data memory plus load/store unit sitting directly downstream of the single-cycle core's ALU.
- The core drives the ALU result as the address and rs2 as the store data.
- The block returns load data, already lane-aligned and sign- or zero-extended, to the register-file write-back mux.
- Loads take two cycles through a synchronous-read RAM; the block raises a stall so the core holds its PC and instruction meanwhile.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; must be a power of two.
- INIT_FILE, "", hex image loaded at elaboration; empty means the contents are left uninitialised.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_read  in  1  load request from control.
- mem_write  in  1  store request from control.
- funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (rs2); the low byte or low half is used for SB/SH.
- read_data  out  32  extended load result; valid only in LOAD_WAIT.
- stall  out  1  core must hold PC and register-file write while high.
- misaligned  out  1  access is misaligned; no memory effect occurs.

Behaviour:
- Word index is address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap modulo the RAM size.
- Misalignment is combinational and applies only when mem_read or mem_write is high:
  - halfword access with address[0]=1;
  - word access with address[1:0]≠00;
  - reserved funct3 (011, 110, 111).
- A misaligned access causes no write, no stall and no FSM transition.
- mem_read and mem_write both high: treated as a load, and the write is suppressed.
- FSM states are IDLE and LOAD_WAIT.
- IDLE:
  - On an aligned mem_read: stall=1 combinationally in that cycle. At the clock edge, the RAM word is latched, address[1:0] and funct3 are captured, and the FSM goes to LOAD_WAIT.
  - On an aligned mem_write (no mem_read): byte lanes are written at the clock edge with stall=0. This is single-cycle.
    - SB writes lane address[1:0].
    - SH writes lanes {address[1],0} and {address[1],1}.
    - SW writes all four lanes.
- LOAD_WAIT:
  - stall=0.
  - read_data is formed combinationally from the latched word and the captured offset and funct3:
    - LB/LH sign-extend bit 7/15 of the selected lane.
    - LBU/LHU zero-extend.
    - LW passes the word through.
  - The next state is always IDLE, regardless of inputs. mem_read is still high in this cycle because the core held the instruction; it is consumed and does not start a new load.
  - mem_write is ignored in LOAD_WAIT.
- read_data is 0 in IDLE.
- Back-to-back loads: a load in the instruction following a load sees IDLE again, stalls one cycle, and proceeds. Throughput is one load per two cycles.
- Store followed by a load to the same word: the load returns the newly stored data, because the write commits at the edge before the load's RAM read.
- Reset:
  - Asynchronously forces IDLE.
  - Captured offset and funct3 go to 0; stall=0, read_data=0, misaligned follows its inputs.
  - Reset asserted during LOAD_WAIT abandons the load.
  - RAM contents are not cleared by reset.
- Load latency is two cycles from request to data, with one stall cycle. Stores take effect at the end of the request cycle.

Test Plan:
- SW 0xDEADBEEF at 0x10, then LW 0x10 -> stall=1 for exactly one cycle; next cycle read_data=0xDEADBEEF and stall=0.
- SB 0x80 at 0x21, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; word 0x20 with other lanes previously 0x00 reads 0x00008000 via LW.
- SH 0x8001 at 0x32, LH 0x32 -> 0xFFFF8001; LHU -> 0x00008001; LH at 0x31 -> misaligned=1, stall=0, no state change.
- SW at 0x13 with write_data 0x11223344 -> misaligned=1, and a subsequent LW 0x10 returns the prior contents unchanged.
- Address 0x400 with DEPTH_WORDS=256: SW 0xA5A5A5A5 -> LW 0x000 returns 0xA5A5A5A5 (wrap).
- LW issued, rst pulsed asynchronously mid-LOAD_WAIT -> stall=0, read_data=0 immediately. After release, the next LW completes normally with the previously stored data.

Source files
------------

// File: rtl/lsu_data_mem.sv
// ---------------------------------------------------------------------------
// lsu_data_mem
//
// Data memory and load/store unit placed right after the core's ALU.
// Stores commit at the end of the request cycle. Loads go through a
// synchronous-read RAM, so they take two cycles. During the first cycle the
// block raises stall, and during the second it returns lane-aligned,
// extended data.
//
// Ports:
//   clk         clock; every state change happens on the rising edge
//   rst         asynchronous reset, active-high
//   mem_read    load request
//   mem_write   store request (ignored when mem_read is also high)
//   funct3      access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   address     byte address; upper bits above the RAM size are ignored
//   write_data  store data; the low byte/half is used for SB/SH
//   read_data   extended load result, nonzero only in LOAD_WAIT
//   stall       core must hold PC and register-file write while high
//   misaligned  access is misaligned or uses a reserved funct3; no effect
// ---------------------------------------------------------------------------
module lsu_data_mem #(
    parameter int    DEPTH_WORDS = 256,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   load_word;
    logic [1:0]    offset_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] word_idx;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic          do_load;
    logic          do_store;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          unused_addr_bits;

    // Addresses wrap modulo the RAM size. The bits above the word index
    // are deliberately dropped.
    assign word_idx         = address[AW+1:2];
    assign unused_addr_bits = ^address[31:AW+2];

    // Size and alignment check. Reserved funct3 encodings are reported
    // the same way as a misaligned access.
    always_comb begin
        misaligned = 1'b0;
        if (mem_read || mem_write) begin
            case (funct3)
                3'b000, 3'b100: misaligned = 1'b0;
                3'b001, 3'b101: misaligned = address[0];
                3'b010:         misaligned = |address[1:0];
                default:        misaligned = 1'b1;
            endcase
        end
    end

    // A load has priority over a simultaneous store. Both are gated by
    // reset, so nothing starts while rst is held.
    assign do_load  = !rst && (state == IDLE) && mem_read && !misaligned;
    assign do_store = !rst && (state == IDLE) && mem_write && !mem_read && !misaligned;

    // Byte-lane enables and replicated store data. This way each lane
    // only ever takes its own slice of wr_lanes.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = write_data;
        case (funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << address[1:0];
                wr_lanes = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en  = address[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{write_data[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = write_data;
            end
        endcase
    end

    // RAM array with a registered read port. It has no reset, so the
    // contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (do_store && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
        if (do_load) begin
            load_word <= mem[word_idx];
        end
    end

    // State register and capture of the load's lane offset and type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            offset_q <= 2'b00;
            funct3_q <= 3'b000;
        end else begin
            state <= state_next;
            if (do_load) begin
                offset_q <= address[1:0];
                funct3_q <= funct3;
            end
        end
    end

    // LOAD_WAIT always returns to IDLE. In that cycle the still-asserted
    // mem_read belongs to the same instruction and is consumed.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (do_load) begin
                    stall      = 1'b1;
                    state_next = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Lane selection and extension of the latched word.
    always_comb begin
        sel_byte  = load_word[8*offset_q +: 8];
        sel_half  = offset_q[1] ? load_word[31:16] : load_word[15:0];
        read_data = 32'h0;
        if (state == LOAD_WAIT) begin
            case (funct3_q)
                3'b000:  read_data = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  read_data = {{16{sel_half[15]}}, sel_half};
                3'b100:  read_data = {24'h0, sel_byte};
                3'b101:  read_data = {16'h0, sel_half};
                default: read_data = load_word;
            endcase
        end
    end

endmodule
